// File: rtl/neopixel_strip_driver.sv
// WS2812-style strip driver: NUM_PIXELS x 24-bit frame buffer serialised G-R-B, MSB first, then a latch gap.
// Define NEOPIX_BRIGHTNESS_EN to add a global brightness input applied at transmit time.
module neopixel_strip_driver #(
  parameter int NUM_PIXELS   = 32,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int T_BIT        = 63,
  parameter int RESET_CYCLES = 2600,
  localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pixel,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
`ifdef NEOPIX_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  input  logic             load,
  input  logic             clear,
  input  logic             go,
  output logic             ready,
  output logic             frame_done,
  output logic             neopixel_data
);

  localparam int CYC_W = (T_BIT > 2) ? $clog2(T_BIT) : 1;
  localparam int LAT_W = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] HI0      = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] HI1      = CYC_W'(T1H);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W:0]   PIX_NUM  = (PIX_W + 1)'(NUM_PIXELS);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t           state, state_nx;
  logic [23:0]      frame_buf [NUM_PIXELS];
  logic [PIX_W-1:0] pix_cnt;
  logic [4:0]       bit_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [23:0]      cur_word, raw_word, tx_word, word;
  logic             first_cyc, bit_val, bit_end, frame_end;

`ifdef NEOPIX_BRIGHTNESS_EN
  logic [7:0] bright_q;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction
`endif

  assign ready = (state == IDLE);

  always_comb begin
    first_cyc = (bit_cnt == 5'd23) && (cyc_cnt == '0);
    raw_word  = frame_buf[pix_cnt];
`ifdef NEOPIX_BRIGHTNESS_EN
    tx_word   = {scale(raw_word[23:16], bright_q), scale(raw_word[15:8], bright_q),
                 scale(raw_word[7:0], bright_q)};
`else
    tx_word   = raw_word;
`endif
    // The first cycle of a pixel reads the buffer directly; later bits use the captured copy.
    word      = first_cyc ? tx_word : cur_word;
    bit_val   = word[bit_cnt];
    bit_end   = (cyc_cnt == CYC_LAST);
    frame_end = bit_end && (bit_cnt == 5'd0) && (pix_cnt == PIX_LAST);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = SEND;
      SEND:    if (frame_end) state_nx = LATCH;
      LATCH:   if (lat_cnt == LAT_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PIXELS; i++) frame_buf[i] <= '0;
    end else if (state == IDLE) begin
      if (clear) begin
        for (int i = 0; i < NUM_PIXELS; i++) frame_buf[i] <= '0;
      end else if (load && ({1'b0, pixel} < PIX_NUM)) begin
        frame_buf[pixel] <= {green, red, blue};
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      pix_cnt       <= '0;
      bit_cnt       <= '0;
      cyc_cnt       <= '0;
      lat_cnt       <= '0;
      cur_word      <= '0;
      frame_done    <= 1'b0;
      neopixel_data <= 1'b0;
`ifdef NEOPIX_BRIGHTNESS_EN
      bright_q      <= '0;
`endif
    end else begin
      frame_done    <= 1'b0;
      neopixel_data <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            pix_cnt  <= '0;
            bit_cnt  <= 5'd23;
            cyc_cnt  <= '0;
`ifdef NEOPIX_BRIGHTNESS_EN
            bright_q <= brightness;
`endif
          end
        end
        SEND: begin
          neopixel_data <= (cyc_cnt < (bit_val ? HI1 : HI0));
          if (first_cyc) cur_word <= tx_word;
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd23;
              pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        LATCH: begin
          // Gap spans RESET_CYCLES low clocks after the last bit's low tail.
          if (lat_cnt == LAT_LAST) begin
            lat_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
